// File: rtl/bcd_to_bin_seq.sv
// Sequential three-digit BCD to 8-bit two's-complement converter.
// Reverse double-dabble: one shift per cycle, start/busy/done handshake, range and digit checks.
module bcd_to_bin_seq #(
    parameter int unsigned ITER = 10,
    parameter bit          SAT  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] centena,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    input  logic       negative,
    output logic       busy,
    output logic       done,
    output logic [7:0] out,
    output logic       overflow,
    output logic       invalid
);

    localparam int unsigned CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [11:0]      r_bcd;
    logic [9:0]       r_bin;
    logic             r_neg;
    logic             r_inv;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_out;
    logic             r_ovf;
    logic             r_invalid;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_digit_bad;
    logic             w_last_iter;
    logic [11:0]      w_bcd_sh;
    logic [11:0]      w_bcd_adj;
    logic [9:0]       w_bin_sh;
    logic             w_in_range;
    logic [7:0]       w_neg_mag;
    logic [7:0]       w_result;
    logic [7:0]       w_sat_val;

    function automatic logic [3:0] f_adj(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    assign w_digit_bad = (centena > 4'd9) | (dezena > 4'd9) | (unidade > 4'd9);
    assign w_last_iter = (r_cnt == CNT_W'(ITER - 1));

    // One reverse double-dabble step: the bcd LSB falls into the binary MSB.
    assign w_bcd_sh  = {1'b0, r_bcd[11:1]};
    assign w_bin_sh  = {r_bcd[0], r_bin[9:1]};
    assign w_bcd_adj = {f_adj(w_bcd_sh[11:8]), f_adj(w_bcd_sh[7:4]), f_adj(w_bcd_sh[3:0])};

    // Only the low byte of the negated magnitude is ever kept.
    assign w_neg_mag  = ~r_bin[7:0] + 8'd1;
    assign w_in_range = r_neg ? (r_bin <= 10'd128) : (r_bin <= 10'd127);
    assign w_result   = r_neg ? w_neg_mag : r_bin[7:0];
    assign w_sat_val  = SAT ? (r_neg ? 8'h80 : 8'h7F) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_digit_bad ? S_FINISH : S_CONV;
                end
            end
            S_CONV: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last_iter) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                busy        = 1'b1;
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd     <= '0;
            r_bin     <= '0;
            r_neg     <= 1'b0;
            r_inv     <= 1'b0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
            r_invalid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_bcd <= {centena, dezena, unidade};
                r_neg <= negative;
                r_inv <= w_digit_bad;
                r_bin <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_bcd <= w_bcd_adj;
                r_bin <= w_bin_sh;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                if (r_inv) begin
                    r_invalid <= 1'b1;
                    r_ovf     <= 1'b0;
                    r_out     <= '0;
                end else begin
                    r_invalid <= 1'b0;
                    r_ovf     <= ~w_in_range;
                    r_out     <= w_in_range ? w_result : w_sat_val;
                end
            end
        end
    end

    assign done     = r_done;
    assign out      = r_out;
    assign overflow = r_ovf;
    assign invalid  = r_invalid;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, hand sequences, sweep and random runs.
// Two instances share stimulus: one saturating, one forcing out to zero on overflow.
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] centena, dezena, unidade;
    logic       negative;

    logic       busy1, done1, ovf1, inv1;
    logic [7:0] out1;
    logic       busy0, done0, ovf0, inv0;
    logic [7:0] out0;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] last1, last0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.ITER(10), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .centena(centena), .dezena(dezena), .unidade(unidade), .negative(negative),
        .busy(busy1), .done(done1), .out(out1), .overflow(ovf1), .invalid(inv1)
    );

    bcd_to_bin_seq #(.ITER(10), .SAT(1'b0)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(start),
        .centena(centena), .dezena(dezena), .unidade(unidade), .negative(negative),
        .busy(busy0), .done(done0), .out(out0), .overflow(ovf0), .invalid(inv0)
    );

    typedef struct {
        logic       neg;
        logic [3:0] c, d, u;
        logic [7:0] eout;
        logic       eovf, einv;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal value from digits, then range rules applied arithmetically.
    task automatic model(input logic neg, input logic [3:0] c, d, u, input bit sat,
                         output logic [7:0] o, output logic ovf, output logic inv);
        int mag;
        mag = int'(c) * 100 + int'(d) * 10 + int'(u);
        o = 8'h00; ovf = 1'b0; inv = 1'b0;
        if (c > 9 || d > 9 || u > 9) begin
            inv = 1'b1;
        end else if ((neg && mag > 128) || (!neg && mag > 127)) begin
            ovf = 1'b1;
            o   = sat ? (neg ? 8'h80 : 8'h7F) : 8'h00;
        end else begin
            o = neg ? 8'(-mag) : 8'(mag);
        end
    endtask

    task automatic wait_done(output int cyc, output logic bok);
        bok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done1) begin
                cyc = k;
                if (busy1) bok = 1'b0;
                return;
            end
            if (!busy1) bok = 1'b0;
        end
        cyc = -1;
    endtask

    task automatic run_conv(input string nm, input logic neg, input logic [3:0] c, d, u);
        logic [7:0] e1, e0;
        logic       eovf, einv, dummy_ovf, dummy_inv, bok;
        int         lat, cyc;
        model(neg, c, d, u, 1'b1, e1, eovf, einv);
        model(neg, c, d, u, 1'b0, e0, dummy_ovf, dummy_inv);
        lat = einv ? 1 : 11;
        @(negedge clk);
        chk({nm, " done one-cycle"}, done1, 1'b0);
        negative = neg; centena = c; dezena = d; unidade = u; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        centena = 4'hF; dezena = 4'hE; unidade = 4'hB; negative = ~neg;
        chk({nm, " busy after start"}, busy1, 1'b1);
        chk({nm, " out held"}, out1, last1);
        wait_done(cyc, bok);
        chk({nm, " latency"}, cyc, lat);
        chk({nm, " busy profile"}, bok, 1'b1);
        chk({nm, " out"}, out1, e1);
        chk({nm, " overflow"}, ovf1, eovf);
        chk({nm, " invalid"}, inv1, einv);
        chk({nm, " done nosat"}, done0, 1'b1);
        chk({nm, " out nosat"}, out0, e0);
        last1 = e1;
        last0 = e0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int         cyc, ndone, mag;
        logic       bok, neg;
        logic [7:0] vb;

        tbl[0]  = '{1'b0, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'd0, 4'd0, 4'd5, 8'hFB, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'd2, 4'd5, 4'd5, 8'h7F, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'd9, 4'd9, 4'd9, 8'h80, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'd0, 4'hA, 4'd3, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'd1, 4'd2, 4'd8, 8'h7F, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'd1, 4'd2, 4'd9, 8'h80, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'd0, 4'd0, 4'd1, 8'hFF, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'd9, 4'hF, 4'd9, 8'h00, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; negative = 1'b0;
        centena = '0; dezena = '0; unidade = '0;
        last1 = 8'h00; last0 = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset busy", busy1, 1'b0);
        chk("reset done", done1, 1'b0);
        chk("reset out", out1, 8'h00);
        chk("reset overflow", ovf1, 1'b0);
        chk("reset invalid", inv1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_conv($sformatf("tbl%0d", i), tbl[i].neg, tbl[i].c, tbl[i].d, tbl[i].u);
            chk($sformatf("tbl%0d out", i), out1, tbl[i].eout);
            chk($sformatf("tbl%0d ovf", i), ovf1, tbl[i].eovf);
            chk($sformatf("tbl%0d inv", i), inv1, tbl[i].einv);
            chk($sformatf("tbl%0d out0", i), out0, (tbl[i].eovf || tbl[i].einv) ? 8'h00 : tbl[i].eout);
        end

        // Reset in the middle of a conversion.
        @(negedge clk);
        negative = 1'b0; centena = 4'd1; dezena = 4'd0; unidade = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", busy1, 1'b0);
        chk("midreset done", done1, 1'b0);
        chk("midreset out", out1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        last1 = 8'h00; last0 = 8'h00;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("midreset stray done", ndone, 0);
        run_conv("after reset 099", 1'b0, 4'd0, 4'd9, 4'd9);
        chk("after reset value", out1, 8'h63);

        // Start pulses while busy are ignored.
        @(negedge clk);
        negative = 1'b0; centena = 4'd0; dezena = 4'd1; unidade = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done1) begin
                cyc = k;
                break;
            end
            if (k == 3 || k == 6) begin
                start = 1'b1; centena = 4'd1; dezena = 4'd0; unidade = 4'd0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy-start latency", cyc, 11);
        chk("busy-start out", out1, 8'h0A);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("busy-start extra done", ndone, 0);
        chk("busy-start idle", busy1, 1'b0);
        last1 = 8'h0A; last0 = 8'h0A;

        // Start held high across done: back-to-back conversions.
        @(negedge clk);
        negative = 1'b0; centena = 4'd0; dezena = 4'd2; unidade = 4'd0; start = 1'b1;
        @(negedge clk);
        wait_done(cyc, bok);
        chk("b2b first latency", cyc, 11);
        chk("b2b first out", out1, 8'h14);
        dezena = 4'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted", busy1, 1'b1);
        wait_done(cyc, bok);
        chk("b2b second latency", cyc, 11);
        chk("b2b second out", out1, 8'h1E);
        last1 = 8'h1E; last0 = 8'h1E;

        // Every representable value.
        for (int v = -128; v <= 127; v++) begin
            mag = (v < 0) ? -v : v;
            run_conv("sweep", v < 0, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10));
            vb = 8'(v);
            chk($sformatf("sweep %0d value", v), out1, vb);
        end

        // Random out-of-range magnitudes.
        for (int i = 0; i < 40; i++) begin
            neg = 1'($urandom_range(0, 1));
            mag = int'($urandom_range(neg ? 129 : 128, 999));
            run_conv("rand ovf", neg, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10));
            chk("rand ovf flag", ovf1, 1'b1);
        end

        // Random raw nibbles, including invalid digits.
        for (int i = 0; i < 60; i++) begin
            run_conv("rand raw", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter for the display and keypad path. It takes a sign flag and three BCD digits (centena/dezena/unidade) and produces an 8-bit two's-complement value. It is the inverse of the team's binary-to-BCD display converter. Conversion uses iterative reverse double-dabble (shift right, then subtract 3 from any digit >= 8) under a start/busy/done handshake, with digit validation and range checking.

Parameters:
ITER, 10, number of shift iterations; 10 covers magnitudes up to 999 (fewer than 1024).
SAT, 1, on overflow: 1 = saturate out to 0x7F/0x80; 0 = out forced to 0x00.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request conversion; sampled only in IDLE
centena  in  4  hundreds BCD digit
dezena  in  4  tens BCD digit
unidade  in  4  units BCD digit
negative  in  1  1 = value is negative
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when out/overflow/invalid become valid
out  out  8  two's-complement result; holds until the next done
overflow  out  1  magnitude out of range; valid with done, held
invalid  out  1  an input digit > 9; valid with done, held

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, out=0x00, overflow=0, invalid=0, internal shift registers and counter cleared.
- States: IDLE, CONV, FINISH.
- IDLE, start=1 at edge E0:
  - capture {centena,dezena,unidade} into 12-bit bcd_r, negative into neg_r; clear 10-bit bin_r; cnt=0.
  - If any digit > 9: inv_r=1, go to FINISH (skip CONV).
  - Otherwise go to CONV. busy=1 from E0.
- CONV, one iteration per edge:
  - shift {bcd_r,bin_r} right by 1.
  - then, in each resulting 4-bit BCD digit, if value >= 8 subtract 3.
  - cnt increments; after the ITER-th iteration (edge E10), go to FINISH.
- FINISH, one edge (E11 on the normal path, E1 on the invalid path):
  - mag = bin_r.
  - Positive limit: mag <= 127. Negative limit: mag <= 128.
  - In range: out = neg_r ? (~mag + 1)[7:0] : mag[7:0], overflow=0.
  - Out of range: overflow=1; out = SAT ? (neg_r ? 0x80 : 0x7F) : 0x00.
  - Invalid input: invalid=1, overflow=0, out=0x00.
  - On a valid completion, invalid is cleared to 0.
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the 11th cycle after the start edge (normal path) or the 1st cycle (invalid path).
- start while busy: ignored; inputs are not re-sampled, so callers may change them freely after E0.
- start=1 in the cycle where done=1 (state is IDLE): accepted as a back-to-back conversion.
- Negative zero (negative=1, 000): out=0x00, overflow=0.
- Reset asserted mid-CONV: immediate return to reset values, no done pulse; the next start behaves normally.
- out/overflow/invalid change only on a FINISH edge or on reset.

Test Plan:
- Reset, then start with neg=0, digits 1,2,7 -> done pulse exactly 11 cycles after the start edge, out=0x7F, overflow=0, invalid=0, busy high for cycles 1-11 then low.
- neg=1, digits 1,2,8 -> out=0x80, overflow=0. neg=1, digits 0,0,5 -> out=0xFB. neg=1, digits 0,0,0 -> out=0x00.
- neg=0, digits 2,5,5 -> overflow=1, out=0x7F (SAT=1). neg=1, digits 9,9,9 -> overflow=1, out=0x80. Repeat with SAT=0 -> out=0x00.
- Digits 0,A,3 -> done 1 cycle after start, invalid=1, out=0x00. Following valid start of 0,4,2 -> out=0x2A, invalid=0.
- Reset asserted at CONV iteration 5, released, then start 0,9,9 -> no stray done; out=0x63 after 11 cycles. Start pulses during busy are ignored. Start held high across done -> second result issued back-to-back.
- Exhaustive sweep of all values -128..127, BCD-encoded by a bench model -> out matches the original value, overflow=0, invalid=0. Random out-of-range magnitudes -> overflow per the limits above.
